// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: arbitrate, register operands,
// execute for one cycle, hold the result until the owner takes it. ALU_ARB_RR_EN selects round-robin.
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*4-1:0]    req_aluop,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_out,
    output logic [2:0]           rsp_flags,
    output logic [3:0]           alu_aluop,
    output logic [31:0]          alu_port_a,
    output logic [31:0]          alu_port_b,
    input  logic [31:0]          alu_port_out,
    input  logic [2:0]           alu_nzv
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [3:0]      aluop_q, aluop_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [31:0]     out_q, out_d;
    logic [2:0]      flags_q, flags_d;

    logic            rsp_hs, window, any_vld, accept;
    logic [IDW-1:0]  win_idx;

    assign rsp_hs = (state_q == RESP) && rsp_ready[owner_q];
    // Reset gates the grant so req_ready reads 0 while nRST is held low.
    assign window = nRST && ((state_q == IDLE) || rsp_hs);
    assign accept = window && any_vld;

`ifdef ALU_ARB_RR_EN
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    // Scan offsets high to low so the nearest valid requester from rr_ptr is assigned last.
    always_comb begin
        int j;
        any_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_valid[j]) begin
                any_vld = 1'b1;
                win_idx = IDW'(j);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept)
            rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        any_vld = 1'b0;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                any_vld = 1'b1;
                win_idx = IDW'(k);
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win_idx] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        aluop_d = aluop_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        flags_d = flags_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_hs) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            owner_d = win_idx;
            aluop_d = req_aluop[int'(win_idx)*4 +: 4];
            a_d     = req_a[int'(win_idx)*32 +: 32];
            b_d     = req_b[int'(win_idx)*32 +: 32];
        end
        if (state_q == EXEC) begin
            out_d   = alu_port_out;
            flags_d = alu_nzv;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= '0;
            aluop_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            aluop_q <= aluop_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign alu_aluop  = aluop_q;
    assign alu_port_a = a_q;
    assign alu_port_b = b_q;
    assign rsp_out    = out_q;
    assign rsp_flags  = flags_q;

endmodule
